// File: rtl/packet_buffer_read_arbiter.sv
// Round-robin drain of per-lane packet FIFOs onto one AXI4-Stream master, whole packets only.
// First beat one cycle after grant, one IDLE bubble between packets; m_tready_i passes straight to the granted lane.
module packet_buffer_read_arbiter #(
    parameter int NUM_LANES      = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_WIDTH      = 11,
    parameter int LANE_IDX_WIDTH = $clog2(NUM_LANES)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     lane_tdata_i     [NUM_LANES],
    input  logic [NUM_LANES-1:0]      lane_tvalid_i,
    output logic [NUM_LANES-1:0]      lane_tready_o,
    input  logic [NUM_LANES-1:0]      lane_pkt_avail_i,
    input  logic [LEN_WIDTH-1:0]      lane_pkt_len_i   [NUM_LANES],
    output logic [NUM_LANES-1:0]      lane_pkt_pop_o,
    output logic [DATA_WIDTH-1:0]     m_tdata_o,
    output logic                      m_tvalid_o,
    output logic                      m_tlast_o,
    input  logic                      m_tready_i,
    output logic [LANE_IDX_WIDTH-1:0] m_lane_o,
    output logic                      busy_o,
    output logic                      len_err_o
);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t                    state_q, state_d;
    logic [LANE_IDX_WIDTH-1:0] grant_q, grant_d;
    logic [LEN_WIDTH-1:0]      remain_q, remain_d;
    logic [LANE_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                      win_found;
    logic [LANE_IDX_WIDTH-1:0] win_idx;
    logic [LANE_IDX_WIDTH-1:0] cand;
    logic                      beat;

    // Search wraps for free because NUM_LANES is a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = rr_ptr_q + LANE_IDX_WIDTH'(i);
            if (!win_found && lane_pkt_avail_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Datapath is gated during reset so an abandoned packet consumes nothing further.
    always_comb begin
        m_tdata_o     = '0;
        m_tvalid_o    = 1'b0;
        m_tlast_o     = 1'b0;
        lane_tready_o = '0;
        beat          = 1'b0;
        if (state_q == ST_XFER && !rst_i) begin
            m_tdata_o              = lane_tdata_i[grant_q];
            m_tvalid_o             = lane_tvalid_i[grant_q];
            m_tlast_o              = (remain_q == LEN_WIDTH'(1));
            lane_tready_o[grant_q] = m_tready_i;
            beat                   = lane_tvalid_i[grant_q] && m_tready_i;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        remain_d       = remain_q;
        rr_ptr_d       = rr_ptr_q;
        lane_pkt_pop_o = '0;
        len_err_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d  = win_idx;
                    remain_d = lane_pkt_len_i[win_idx];
                    rr_ptr_d = win_idx + LANE_IDX_WIDTH'(1);
                    if (lane_pkt_len_i[win_idx] == '0) begin
                        lane_pkt_pop_o[win_idx] = !rst_i;
                        len_err_o               = !rst_i;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (beat) begin
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        lane_pkt_pop_o[grant_q] = 1'b1;
                        state_d                 = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            remain_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            remain_q <= remain_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign m_lane_o = grant_q;
    assign busy_o   = (state_q == ST_XFER);

endmodule

// File: doc/packet_buffer_read_arbiter.md
# packet_buffer_read_arbiter

Drains the per-lane byte FIFOs of the packet buffer into a single byte-wide AXI4-Stream master, one whole packet at a time. Lanes holding at least one complete packet are granted round-robin. Each lane supplies a head-of-queue descriptor (packet length), and the arbiter emits exactly that many beats with `tlast` on the final one. It sits between the packet buffer lane outputs and the downstream parser/capture logic, and keeps packets from different lanes from interleaving.

## Interface

- `NUM_LANES`, 8: number of buffer lanes; power of two, ≥2.
- `DATA_WIDTH`, 8: lane and output beat width.
- `LEN_WIDTH`, 11: packet length field width in bytes; covers `MAX_PACKET_LENGTH`.
- `LANE_IDX_WIDTH`, `$clog2(NUM_LANES)`: lane index width.

Ports:

- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `lane_tdata_i[NUM_LANES]` in `DATA_WIDTH`: lane FIFO read data.
- `lane_tvalid_i[NUM_LANES]` in 1: lane FIFO data valid.
- `lane_tready_o[NUM_LANES]` out 1: lane FIFO read enable.
- `lane_pkt_avail_i[NUM_LANES]` in 1: lane holds ≥1 complete packet.
- `lane_pkt_len_i[NUM_LANES]` in `LEN_WIDTH`: head packet length in bytes; valid while avail is high.
- `lane_pkt_pop_o[NUM_LANES]` out 1: one-cycle pulse; retire the head descriptor.
- `m_tdata_o` out `DATA_WIDTH`: output beat.
- `m_tvalid_o` out 1: output valid.
- `m_tlast_o` out 1: final beat of packet.
- `m_tready_i` in 1: downstream ready.
- `m_lane_o` out `LANE_IDX_WIDTH`: lane currently granted.
- `busy_o` out 1: high in XFER.
- `len_err_o` out 1: one-cycle pulse on a zero-length descriptor.

## Operation

- States are IDLE and XFER. Registered state holds `grant_r` (lane index), `remain_r` (`LEN_WIDTH`) and `rr_ptr_r` (`LANE_IDX_WIDTH`).
- **IDLE, arbitration:**
  - Search starts at `rr_ptr_r` and runs upward, modulo `NUM_LANES`. The first lane with avail=1 wins.
  - The winner's index goes to `grant_r`, its `lane_pkt_len_i` to `remain_r`, and `rr_ptr_r` becomes winner+1 (wraps `NUM_LANES-1`→0).
- **IDLE, zero-length descriptor:** if the winner's length is 0, stay in IDLE.
  - Pulse `lane_pkt_pop_o[winner]` and `len_err_o` in the same cycle.
  - No output beat; `rr_ptr_r` still advances.
- **IDLE, nonzero length:** go to XFER.
- **XFER, datapath pass-through (combinational):**
  - `m_tdata_o = lane_tdata_i[grant_r]`, `m_tvalid_o = lane_tvalid_i[grant_r]`, `lane_tready_o[grant_r] = m_tready_i`.
  - All other `lane_tready_o` are 0.
  - `m_tlast_o = (remain_r == 1)`.
- **XFER, beat counting:** a beat is `m_tvalid_o && m_tready_i`. Each beat decrements `remain_r`.
- **XFER, last beat** (beat with `remain_r == 1`):
  - `lane_pkt_pop_o[grant_r]` pulses in the same cycle.
  - Next state is IDLE.
- **Outside XFER:** `m_tvalid_o`, `m_tlast_o` and all `lane_tready_o` are 0, and `busy_o` is 0.
- **Stalls:** lane valid low mid-packet stalls without limit. No timeout, no abort.
- **Lane isolation:** avail/len changes on non-granted lanes have no effect during XFER. The granted lane's len is not re-sampled after the grant.
- **Lane FIFO contract:** avail/len must reflect a pop by the cycle after the pop pulse.

## Timing

- **Reset:** IDLE, `rr_ptr_r=0`, `grant_r=0`, `remain_r=0`. All outputs are 0, including `m_lane_o=0`.
- **Reset mid-packet:** abandon the packet with no pop pulse. On the cycle after reset deasserts, lane 0 has highest priority.
- **Arbitration latency:** avail seen in IDLE at cycle N gives the first possible beat at N+1.
- **Back-to-back packets:** exactly one IDLE bubble follows each packet's last beat. A packet of L bytes with no backpressure occupies L+1 cycles.
- **Throughput:** no added latency per beat. `m_tready_i` goes combinationally to `lane_tready_o`.
- **Stable while stalled:** `m_lane_o` and `busy_o` are registered and stay stable through backpressure.
- **Zero-length pop:** a zero-length descriptor costs one IDLE cycle. The next arbitration happens the following cycle.

## Test plan

- **Single packet:** lane 3 avail, len=5, bytes 0x10..0x14, `m_tready_i`=1.
  - Beats 0x10..0x14 on cycles N+1..N+5, with `tlast` only on 0x14.
  - Pop[3] pulses at N+5; `m_lane_o`=3.
- **Round-robin:** lanes 0, 2 and 7 each hold one 2-byte packet.
  - Grant order is 0, 2, 7, then idle.
  - Then add a packet on lane 1: it is granted next (`rr_ptr` wrapped to 0).
- **Backpressure and stall:** len=4, `m_tready_i` toggles 1010…, lane valid low for 3 cycles mid-packet.
  - Exactly 4 beats, data in order, `tlast` on the 4th.
  - `lane_tready_o` mirrors `m_tready_i` only on the granted lane.
- **Zero length:** lane 5 has len=0, lane 6 has len=2.
  - `len_err_o` and pop[5] pulse together with no beat.
  - Lane 6 is granted the next cycle and emits 2 beats.
- **Max length:** len=2047 (all ones) with continuous data.
  - 2047 beats and `tlast` on the last only; `remain_r` is 0 afterwards.
- **Reset mid-packet:** assert `rst_i` after 3 of 8 beats.
  - No pop pulse; all outputs are 0 the cycle after.
  - After release with lanes 0 and 4 avail, lane 0 is granted first.
